// File: rtl/updown_cmd_sched_if.sv
// updown_cmd_sched_if
//   Groups the requester-side command bus and the counter-side control bus of
//   the up/down counter command scheduler.
//   master : requester/environment view (drives req/op/arg, observes the rest)
//   slave  : scheduler view (samples req/op/arg, drives grants, counter
//            controls, status and the tracked shadow value)
//   Handshake: a requester raises req[i] with op/arg stable and holds it until
//   it sees ack[i] (a one-cycle pulse); op/arg are sampled only on the grant
//   edge, and req[i] is ignored during its own ack cycle.
interface updown_cmd_sched_if #(
    parameter int W = 8
);
    logic [1:0]   req;
    logic [1:0]   op0;
    logic [W-1:0] arg0;
    logic [1:0]   op1;
    logic [W-1:0] arg1;
    logic [1:0]   ack;
    logic         ctr_ld;
    logic         ctr_clr;
    logic         ctr_mode;
    logic [W-1:0] ctr_din;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] shadow;
    logic [1:0]   dbg_state;

    modport master (
        output req, op0, arg0, op1, arg1,
        input  ack, ctr_ld, ctr_clr, ctr_mode, ctr_din,
        input  busy, done, done_id, shadow, dbg_state
    );

    modport slave (
        input  req, op0, arg0, op1, arg1,
        output ack, ctr_ld, ctr_clr, ctr_mode, ctr_din,
        output busy, done, done_id, shadow, dbg_state
    );
endinterface

// File: rtl/updown_cmd_sched.sv
// updown_cmd_sched
//   Arbitrates two requesters issuing LOAD / CLEAR / UP-by-N / DOWN-by-N
//   commands and sequences the control inputs of an enable-less 8-bit up/down
//   counter. Between commands the counter is held by reloading a tracked
//   shadow copy every cycle.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : updown_cmd_sched_if.slave
//            req/op0/arg0/op1/arg1 in; ack, ctr_ld/ctr_clr/ctr_mode/ctr_din,
//            busy, done, done_id, shadow, dbg_state (FSM state) out
module updown_cmd_sched #(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    updown_cmd_sched_if.slave  bus
);
    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_UP    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CLR  = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] shadow;
    logic [1:0]   ack;
    logic         done;
    logic         done_id;
    logic         rr;       // last winner of a contested round
    logic [W-1:0] arg_q;
    logic         dir_q;    // 1 = up
    logic         id_q;
    logic [W-1:0] rem;

    logic [1:0]   elig;
    logic         any_elig;
    logic         win;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_arg;

    // A requester in its ack cycle is masked so a still-high req cannot be
    // granted twice for one command.
    always_comb begin
        elig     = bus.req & ~ack;
        any_elig = |elig;
        if (elig == 2'b11)
            win = ~rr;
        else
            win = elig[1];
        sel_op  = win ? bus.op1  : bus.op0;
        sel_arg = win ? bus.arg1 : bus.arg0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shadow  <= '0;
            ack     <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
            rr      <= 1'b1;
            arg_q   <= '0;
            dir_q   <= 1'b0;
            id_q    <= 1'b0;
            rem     <= '0;
        end else begin
            ack  <= '0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_elig) begin
                        ack   <= win ? 2'b10 : 2'b01;
                        id_q  <= win;
                        arg_q <= sel_arg;
                        dir_q <= (sel_op == OP_UP);
                        rem   <= sel_arg;
                        if (elig == 2'b11)
                            rr <= win;
                        case (sel_op)
                            OP_LOAD:  state <= S_LOAD;
                            OP_CLEAR: state <= S_CLR;
                            default: begin
                                // A zero-length step completes on the grant edge.
                                if (sel_arg == '0) begin
                                    done    <= 1'b1;
                                    done_id <= win;
                                end else begin
                                    state <= S_STEP;
                                end
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    shadow  <= arg_q;
                    state   <= S_IDLE;
                    done    <= 1'b1;
                    done_id <= id_q;
                end
                S_CLR: begin
                    shadow  <= '0;
                    state   <= S_IDLE;
                    done    <= 1'b1;
                    done_id <= id_q;
                end
                S_STEP: begin
                    shadow <= dir_q ? shadow + 1'b1 : shadow - 1'b1;
                    rem    <= rem - 1'b1;
                    if (rem == {{(W-1){1'b0}}, 1'b1}) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        done_id <= id_q;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counter controls are a pure decode of registered state.
    always_comb begin
        bus.ctr_ld   = 1'b0;
        bus.ctr_clr  = 1'b0;
        bus.ctr_mode = 1'b0;
        bus.ctr_din  = '0;
        case (state)
            S_IDLE: begin
                bus.ctr_ld  = 1'b1;
                bus.ctr_din = shadow;
            end
            S_LOAD: begin
                bus.ctr_ld  = 1'b1;
                bus.ctr_din = arg_q;
            end
            S_CLR: begin
                bus.ctr_clr = 1'b1;
            end
            S_STEP: begin
                bus.ctr_mode = dir_q;
            end
            default: begin
                bus.ctr_ld = 1'b1;
            end
        endcase
    end

    assign bus.ack       = ack;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done;
    assign bus.done_id   = done_id;
    assign bus.shadow    = shadow;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_updown_cmd_sched.sv
// tb_updown_cmd_sched
//   Drives directed command sequences into updown_cmd_sched, models the
//   attached up/down counter, and checks grants and completions against
//   hand-computed expectations held in queues.
module tb_updown_cmd_sched;
    localparam int W  = 8;
    localparam int DW = 8 + 1 + W;   // {busy cycles, id, final value}

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_UP    = 2'd2;
    localparam logic [1:0] OP_DOWN  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    updown_cmd_sched_if #(.W(W)) bus ();

    updown_cmd_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- counter model ----------------
    logic [W-1:0] cnt_model = 8'hAA;
    always @(posedge clk) begin
        if (bus.ctr_clr)
            cnt_model <= '0;
        else if (bus.ctr_ld)
            cnt_model <= bus.ctr_din;
        else if (bus.ctr_mode)
            cnt_model <= cnt_model + 1'b1;
        else
            cnt_model <= cnt_model - 1'b1;
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [1:0]    ack_q[$];
    int busy_cnt  = 0;
    int clr_total = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_done(input int bcyc, input logic id, input logic [W-1:0] val);
        exp_q.push_back({8'(bcyc), id, val});
    endfunction

    always @(negedge clk) begin
        if (bus.ctr_clr && !rst)
            clr_total++;
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic [1:0]    a;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy)
                busy_cnt++;
            if (bus.ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", int'(bus.ack), 0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack", int'(bus.ack), int'(a));
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_id",     int'(bus.done_id), int'(e[W]));
                    chk("done_shadow", int'(bus.shadow),  int'(e[W-1:0]));
                    chk("done_counter", int'(cnt_model),  int'(e[W-1:0]));
                    chk("busy_cycles", busy_cnt,          int'(e[DW-1:W+1]));
                end
                busy_cnt = 0;
            end
            if (!bus.busy)
                chk("idle_track", int'(cnt_model), int'(bus.shadow));
        end
    end

    // ---------------- driver tasks ----------------
    // Raise req for the requesters in 'who' and drop each one on the edge
    // after its ack is seen.
    task automatic serve(input logic [1:0] who);
        logic [1:0] pend;
        logic [1:0] drop;
        int n;
        pend = who;
        n = 0;
        bus.req = bus.req | who;
        while (pend != 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
            drop = bus.ack & pend;
            @(posedge clk);
            #1;
            bus.req = bus.req & ~drop;
            pend    = pend & ~drop;
        end
        if (pend != 2'b00) begin
            chk("ack_timeout", int'(pend), 0);
            bus.req = 2'b00;
        end
    endtask

    task automatic cmd(input logic id, input logic [1:0] op, input logic [W-1:0] arg);
        if (id) begin
            bus.op1 = op;
            bus.arg1 = arg;
        end else begin
            bus.op0 = op;
            bus.arg0 = arg;
        end
        ack_q.push_back(id ? 2'b10 : 2'b01);
        serve(id ? 2'b10 : 2'b01);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300)
            chk("quiet_timeout", n, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req  = 2'b00;
        bus.op0  = OP_LOAD;
        bus.arg0 = '0;
        bus.op1  = OP_LOAD;
        bus.arg1 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, no requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ctr_ld",  int'(bus.ctr_ld), 1);
            chk("rst_ctr_din", int'(bus.ctr_din), 0);
            chk("rst_counter", int'(cnt_model), 0);
            chk("rst_busy",    int'(bus.busy), 0);
            chk("rst_ack",     int'(bus.ack), 0);
        end
        @(posedge clk);
        #1;

        // LOAD 100 then UP 3, back to back from requester 0.
        push_done(1, 1'b0, 8'd100);
        cmd(1'b0, OP_LOAD, 8'd100);
        push_done(3, 1'b0, 8'd103);
        cmd(1'b0, OP_UP, 8'd3);
        wait_quiet();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_shadow", int'(bus.shadow), 103);
        end
        @(posedge clk);
        #1;

        // Contested round from counter 1: requester 0 wins first.
        push_done(1, 1'b1, 8'd1);
        cmd(1'b1, OP_LOAD, 8'd1);
        wait_quiet();
        bus.op0 = OP_DOWN;
        bus.arg0 = 8'd2;
        bus.op1 = OP_LOAD;
        bus.arg1 = 8'd7;
        ack_q.push_back(2'b01);
        ack_q.push_back(2'b10);
        push_done(2, 1'b0, 8'd255);
        push_done(1, 1'b1, 8'd7);
        serve(2'b11);
        wait_quiet();

        // Next contested round goes to requester 1 first.
        bus.op0 = OP_LOAD;
        bus.arg0 = 8'd42;
        bus.op1 = OP_LOAD;
        bus.arg1 = 8'd50;
        ack_q.push_back(2'b10);
        ack_q.push_back(2'b01);
        push_done(1, 1'b1, 8'd50);
        push_done(1, 1'b0, 8'd42);
        serve(2'b11);
        wait_quiet();

        // Zero-length UP: ack and done together, never busy.
        push_done(0, 1'b1, 8'd42);
        cmd(1'b1, OP_UP, 8'd0);
        wait_quiet();
        chk("zero_step_shadow", int'(bus.shadow), 42);

        // CLEAR from 200.
        push_done(1, 1'b0, 8'd200);
        cmd(1'b0, OP_LOAD, 8'd200);
        wait_quiet();
        chk("clr_before", clr_total, 0);
        push_done(1, 1'b0, 8'd0);
        cmd(1'b0, OP_CLEAR, 8'd99);
        wait_quiet();
        chk("clr_cycles", clr_total, 1);

        // UP 10 from 5, aborted by reset after 4 steps.
        push_done(1, 1'b0, 8'd5);
        cmd(1'b0, OP_LOAD, 8'd5);
        wait_quiet();
        bus.op0 = OP_UP;
        bus.arg0 = 8'd10;
        ack_q.push_back(2'b01);
        bus.req = 2'b01;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (bus.ack[0] !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50)
                chk("abort_ack_timeout", n, 0);
        end
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_pre_counter", int'(cnt_model), 9);
        rst = 1'b1;
        #1;
        chk("abort_busy",    int'(bus.busy), 0);
        chk("abort_shadow",  int'(bus.shadow), 0);
        chk("abort_done",    int'(bus.done), 0);
        chk("abort_ack",     int'(bus.ack), 0);
        chk("abort_ctr_ld",  int'(bus.ctr_ld), 1);
        chk("abort_ctr_din", int'(bus.ctr_din), 0);
        @(posedge clk);
        #1;
        chk("abort_counter", int'(cnt_model), 0);
        rst = 1'b0;

        push_done(1, 1'b0, 8'd9);
        cmd(1'b0, OP_LOAD, 8'd9);
        wait_quiet();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
